// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [3:0] SEL_READ   = 4'b0000;
    localparam int         WAIT_CNT_W = 4;

endpackage : dmem_pkg

// File: rtl/dmem_bram_be.sv
// Single-port 32-bit RAM with four byte-lane write enables and a read-first registered output.
module dmem_bram_be
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    // NOTE: memory array and its output register have no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule : dmem_bram_be

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE -> WAIT* -> ACCESS -> RESP with a one-cycle ack.
// Build option DMEM_RANGE_CHECK_EN flags out-of-range addresses with err instead of wrapping.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam state_e ACCEPT_NEXT = (WAIT_CYCLES > 0) ? WAIT : ACCESS;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   word_q, word_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    oor_q, oor_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    oor_in;
    logic                    unused_addr;
    logic [3:0]              ram_we;
    logic [31:0]             ram_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_in      = |addr[31:ADDR_WIDTH+2];
    assign unused_addr = ^addr[1:0];
`else
    assign oor_in      = 1'b0;
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    sel_d   = sel;
                    word_d  = addr[ADDR_WIDTH+1:2];
                    wdata_d = wdata;
                    oor_d   = oor_in;
                    cnt_d   = CNT_INIT;
                    state_d = ACCEPT_NEXT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
        ack_d  = (state_q == ACCESS);
        err_d  = (state_q == ACCESS) && oor_q;
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Out-of-range and read accesses never touch RAM contents.
    assign ram_we = (sel_q == SEL_READ || oor_q) ? 4'b0000 : sel_q;

    dmem_bram_be #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (state_q == ACCESS),
        .we   (ram_we),
        .addr (word_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign rdata = (state_q == RESP && !err_q) ? ram_rdata : 32'h0;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance (1 wait state) and a zero-wait instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, busy_a, busy_b, err_a, err_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .sel(sel), .addr(addr), .wdata(wdata),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .sel(sel), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b)
    );

    // Starts in an IDLE cycle (#1 after an edge); returns #1 into the IDLE cycle after ack.
    task automatic do_access(input bit inst, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] w, output int cyc, output logic [31:0] rd,
                             output logic er, output logic [31:0] post_rd, output logic post_busy);
        sel = s; addr = a; wdata = w;
        if (inst) req_b = 1'b1; else req_a = 1'b1;
        cyc = -1; rd = '0; er = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if ((inst ? ack_b : ack_a) === 1'b1) begin
                cyc = k;
                rd  = inst ? rdata_b : rdata_a;
                er  = inst ? err_b : err_a;
                break;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
        post_rd   = inst ? rdata_b : rdata_a;
        post_busy = inst ? busy_b : busy_a;
    endtask

    task automatic test_reset();
        int c; logic [31:0] rd, prd; logic er, pb;
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1;
        sel = 4'b1111; addr = 32'h10; wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if ({ack_a, err_a, busy_a, rdata_a, ack_b, err_b, busy_b, rdata_b} !== 70'h0)
                $display("FAIL reset_outputs cycle %0d: a ack=%b err=%b busy=%b rdata=%h b ack=%b err=%b busy=%b rdata=%h, expected all 0",
                         k, ack_a, err_a, busy_a, rdata_a, ack_b, err_b, busy_b, rdata_b);
            else passed++;
        end
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, c, rd, er, prd, pb);
        total++;
        if (c !== 3) $display("FAIL first_write_ack_cycle: got %0d, expected 3", c);
        else passed++;
        total++;
        if (er !== 1'b0 || prd !== 32'h0 || pb !== 1'b0)
            $display("FAIL first_write_post: err=%b post_rdata=%h post_busy=%b, expected 0/0/0", er, prd, pb);
        else passed++;
    endtask

    task automatic test_full_read();
        int c; logic [31:0] rd, prd; logic er, pb;
        do_access(1'b0, 4'b0000, 32'h10, 32'h0, c, rd, er, prd, pb);
        total++;
        if (c !== 3) $display("FAIL read_ack_cycle: got %0d, expected 3", c);
        else passed++;
        total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL read_full_word: got %h, expected deadbeef", rd);
        else passed++;
        total++;
        if (prd !== 32'h0 || pb !== 1'b0)
            $display("FAIL read_post_ack: rdata=%h busy=%b, expected 00000000/0", prd, pb);
        else passed++;
    endtask

    task automatic test_byte_lane();
        int c; logic [31:0] rd, prd; logic er, pb;
        do_access(1'b0, 4'b0010, 32'h10, 32'h00005A00, c, rd, er, prd, pb);
        total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL byte_write_old_word: got %h, expected deadbeef", rd);
        else passed++;
        do_access(1'b0, 4'b0000, 32'h10, 32'h0, c, rd, er, prd, pb);
        total++;
        if (rd !== 32'hDEAD5AEF) $display("FAIL byte_lane_merge: got %h, expected dead5aef", rd);
        else passed++;
    endtask

    task automatic test_out_of_range();
        int c; logic [31:0] rd, prd; logic er, pb;
        logic [31:0] exp_rd_hi, exp_w0; logic exp_err;
`ifdef DMEM_RANGE_CHECK_EN
        exp_err = 1'b1; exp_rd_hi = 32'h0; exp_w0 = 32'h01234567;
`else
        exp_err = 1'b0; exp_rd_hi = 32'h11111111; exp_w0 = 32'h11111111;
`endif
        do_access(1'b0, 4'b1111, 32'h0, 32'h01234567, c, rd, er, prd, pb);
        do_access(1'b0, 4'b1111, 32'h00001000, 32'h11111111, c, rd, er, prd, pb);
        total++;
        if (c !== 3 || er !== exp_err)
            $display("FAIL oor_write: ack_cycle=%0d err=%b, expected 3/%b", c, er, exp_err);
        else passed++;
        do_access(1'b0, 4'b0000, 32'h00001000, 32'h0, c, rd, er, prd, pb);
        total++;
        if (er !== exp_err || rd !== exp_rd_hi)
            $display("FAIL oor_read: err=%b rdata=%h, expected %b/%h", er, rd, exp_err, exp_rd_hi);
        else passed++;
        do_access(1'b0, 4'b0000, 32'h0, 32'h0, c, rd, er, prd, pb);
        total++;
        if (er !== 1'b0 || rd !== exp_w0)
            $display("FAIL oor_word0: err=%b rdata=%h, expected 0/%h", er, rd, exp_w0);
        else passed++;
    endtask

    task automatic run_b2b(input bit inst, input int exp_c1, input int exp_c2,
                           input logic [31:0] exp_r1, input logic [31:0] exp_r2, input string tag);
        int c1, c2, n; logic [31:0] r1, r2;
        c1 = -1; c2 = -1; n = 0; r1 = '0; r2 = '0;
        sel = 4'b0000; addr = 32'h10; wdata = 32'h0;
        if (inst) req_b = 1'b1; else req_a = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if ((inst ? ack_b : ack_a) === 1'b1) begin
                if (n == 0) begin
                    c1 = k; r1 = inst ? rdata_b : rdata_a; addr = 32'h14; n = 1;
                end else begin
                    c2 = k; r2 = inst ? rdata_b : rdata_a;
                    break;
                end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
        total++;
        if (c1 !== exp_c1 || c2 !== exp_c2)
            $display("FAIL %s_ack_cycles: got %0d,%0d expected %0d,%0d", tag, c1, c2, exp_c1, exp_c2);
        else passed++;
        total++;
        if (r1 !== exp_r1 || r2 !== exp_r2)
            $display("FAIL %s_rdata: got %h,%h expected %h,%h", tag, r1, r2, exp_r1, exp_r2);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c; logic [31:0] rd, prd; logic er, pb;
        do_access(1'b0, 4'b1111, 32'h14, 32'h0BADF00D, c, rd, er, prd, pb);
        run_b2b(1'b0, 3, 7, 32'hDEAD5AEF, 32'h0BADF00D, "b2b_wait1");
        do_access(1'b1, 4'b1111, 32'h10, 32'hA5A5A5A5, c, rd, er, prd, pb);
        total++;
        if (c !== 2) $display("FAIL wait0_write_ack_cycle: got %0d, expected 2", c);
        else passed++;
        do_access(1'b1, 4'b1111, 32'h14, 32'h5A5A5A5A, c, rd, er, prd, pb);
        run_b2b(1'b1, 2, 5, 32'hA5A5A5A5, 32'h5A5A5A5A, "b2b_wait0");
    endtask

    task automatic test_reset_mid_op();
        int c; logic [31:0] rd, prd; logic er, pb; logic saw_ack;
        do_access(1'b0, 4'b1111, 32'h20, 32'h13572468, c, rd, er, prd, pb);
        sel = 4'b1111; addr = 32'h20; wdata = 32'hCAFEF00D; req_a = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy_a !== 1'b1) $display("FAIL midrst_busy_in_wait: got %b, expected 1", busy_a);
        else passed++;
        #2 rst = 1'b0; req_a = 1'b0;
        #1;
        total++;
        if (busy_a !== 1'b0 || ack_a !== 1'b0)
            $display("FAIL midrst_async_clear: busy=%b ack=%b, expected 0/0", busy_a, ack_a);
        else passed++;
        saw_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack_a !== 1'b0) saw_ack = 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ack_a !== 1'b0) saw_ack = 1'b1;
        end
        total++;
        if (saw_ack !== 1'b0) $display("FAIL midrst_no_ack: ack seen=%b, expected 0", saw_ack);
        else passed++;
        do_access(1'b0, 4'b0000, 32'h20, 32'h0, c, rd, er, prd, pb);
        total++;
        if (c !== 3 || rd !== 32'h13572468)
            $display("FAIL midrst_prior_value: ack_cycle=%0d rdata=%h, expected 3/13572468", c, rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_read();
        test_byte_lane();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MIPS core's data-memory port.
- Accepts word/byte-lane read and write requests (request, byte select, address, write data) and services them from an internal byte-enable RAM after a configurable number of wait states.
- Completes each access with a one-cycle acknowledge carrying the read data.
- Replaces the zero-wait data memory once the core gains a stall path; the core stalls on busy/ack.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- WAIT_CYCLES, 1, wait states inserted before the RAM access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; held by the core until ack.
- sel  in  4  byte-lane write enables; 4'b0000 means read.
- addr  in  32  byte address; addr[1:0] ignored, word index = addr[ADDR_WIDTH+1:2].
- wdata  in  32  write data, lane-aligned (lane i = wdata[8i+7:8i]).
- rdata  out  32  read data; valid only while ack=1.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- err  out  1  out-of-range flag; meaningful with ack only.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ack=0, err=0, busy=0, rdata=0; wait counter=0.
  - An in-flight request is dropped with no write and no ack.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If req=1 at a clock edge, latch sel/addr/wdata and load counter=WAIT_CYCLES-1.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: decrement counter; when counter==0, go to ACCESS.
- ACCESS:
  - One RAM cycle. Write lanes where sel[i]=1; unselected lanes are unchanged.
  - Read returns the full word, pre-write value for writes (read-first).
  - Next state is RESP.
- RESP:
  - ack=1 for exactly one cycle; rdata holds the registered RAM output; next state is IDLE.
  - req is ignored during RESP.
- Latency: req sampled at the end of cycle 0 → ack in cycle WAIT_CYCLES+2.
  - Default: ack in cycle 3. WAIT_CYCLES=0: ack in cycle 2.
- Back-to-back: if req is still high in the IDLE cycle after ack, it is a new request. The core must drop req in the cycle after ack unless it is issuing a new access.
- Inputs are latched at acceptance; changes on sel/addr/wdata during WAIT/ACCESS/RESP have no effect.
- rdata is cleared to 0 in the cycle after ack. For writes, rdata during ack = old word.
- Out of range = addr[31:ADDR_WIDTH+2] != 0; handling is defined under Optional Feature.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined: an out-of-range access still follows the full FSM timing.
  - ack=1 with err=1, rdata=0, no RAM write.
- Undefined: upper address bits are ignored and the word index wraps modulo 2^ADDR_WIDTH. err is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP, 2-bit encoding);
  - SEL_READ = 4'b0000;
  - WAIT_CNT_W = 4.
- Sub-module dmem_bram_be: single-port 32-bit RAM with 4 byte enables and read-first registered output. Behavioural; synthesises to BRAM.
- The FSM, counter, input latch and range check stay in dmem_responder.

Test Plan:
- Reset: hold rst=0 with req=1 → ack=0, err=0, busy=0, rdata=0 throughout. Release rst → the first access completes normally.
- Full write then read: write addr=0x10, sel=4'b1111, wdata=0xDEADBEEF → ack in cycle 3. Read 0x10 → ack in cycle 3, rdata=0xDEADBEEF.
- Byte lane: write addr=0x10, sel=4'b0010, wdata=0x00005A00, then read 0x10 → rdata=0xDEAD5AEF.
- Out of range: write addr=0x00001000, wdata=0x11111111, then read it.
  - EN build: ack=1, err=1, rdata=0, and word 0 is unchanged.
  - Non-EN build: err=0, word 0 reads 0x11111111.
- Back-to-back and latency: hold req high across ack for reads of 0x10 then 0x14 → acks in cycles 3 and 7. A WAIT_CYCLES=0 instance → acks in cycles 2 and 5.
- Reset mid-operation: start a write of 0xCAFEF00D to 0x20, pull rst low during WAIT → no ack. After release, a read of 0x20 returns the prior value.
